board_io_ctrl: RTL and testbench

//   Parametrised board I/O peripheral on the J1 I/O bus. It replaces the fixed key/switch/LED/HEX glue.
//   - Debounces and edge-captures push-buttons.
//   - Samples switches; drives LEDs and 7-segment digits from CPU-written registers.
//   - Owns the USB low-speed 1.5 kOhm pull-up (attach) with a CPU-triggered, timed soft-detach.

---
 rtl/board_io_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_board_io_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O peripheral on the J1 I/O bus: debounced keys with edge capture, switches,
// LEDs, 7-segment digits and the USB pull-up with a timed soft-detach.
//
// state  | meaning
// IDLE   | usb_attach follows attach_en
// DETACH | pull-up released while the detach timer runs down
module board_io_ctrl #(
  parameter logic [15:0] BASE_ADDR       = 16'h0010,
  parameter int          NUM_KEYS        = 4,
  parameter int          NUM_SW          = 10,
  parameter int          NUM_LEDG        = 8,
  parameter int          NUM_LEDR        = 10,
  parameter int          NUM_HEX         = 4,
  parameter int          DEBOUNCE_CYCLES = 480000,
  parameter int          DETACH_CYCLES   = 480000,
  parameter bit          ATTACH_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_rd,
  input  logic                  io_wr,
  input  logic [15:0]           io_addr,
  input  logic [15:0]           io_dout,
  output logic [15:0]           io_din,
  input  logic [NUM_KEYS-1:0]   key,
  input  logic [NUM_SW-1:0]     sw,
  output logic [7*NUM_HEX-1:0]  hex,
  output logic [NUM_LEDG-1:0]   ledg,
  output logic [NUM_LEDR-1:0]   ledr,
  output logic                  usb_attach
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int DET_W = $clog2(DETACH_CYCLES + 1);
  localparam logic [DET_W-1:0] DET_LOAD = DET_W'(DETACH_CYCLES);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] DETACH = 1'b1;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  logic                   hit, rd_hit, wr_hit, detach_req;
  logic [2:0]             offset;
  logic [NUM_KEYS-1:0]    key_meta, key_sync, key_deb, key_edge, press, edge_clr;
  logic [NUM_SW-1:0]      sw_meta, sw_sync;
  logic [DB_W-1:0]        db_cnt [NUM_KEYS];
  logic [4*NUM_HEX-1:0]   hex_val;
  logic                   attach_en, busy;
  logic [0:0]             state;
  logic [DET_W-1:0]       det_cnt;
  logic [15:0]            rdata;

  assign hit        = (io_addr[15:3] == BASE_ADDR[15:3]);
  assign offset     = io_addr[2:0];
  assign rd_hit     = io_rd & hit;
  assign wr_hit     = io_wr & hit;
  assign detach_req = wr_hit & (offset == 3'd6) & io_dout[1];
  assign edge_clr   = (wr_hit && offset == 3'd1) ? io_dout[NUM_KEYS-1:0] : '0;

  // keys idle high (released), so the synchronisers and debounced state reset to ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      press[i] = key_deb[i] & ~key_sync[i] & (db_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_deb  <= '1;
      key_edge <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sync[i] != key_deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            key_deb[i] <= ~key_deb[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      key_edge <= (key_edge & ~edge_clr) | press;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_val   <= '0;
      hex       <= '1;
      ledg      <= '0;
      ledr      <= '0;
      attach_en <= ATTACH_ON_RESET;
    end else if (wr_hit) begin
      case (offset)
        3'd3: begin
          hex_val <= io_dout[4*NUM_HEX-1:0];
          for (int d = 0; d < NUM_HEX; d++) hex[7*d +: 7] <= seg7(io_dout[4*d +: 4]);
        end
        3'd4: ledg <= io_dout[NUM_LEDG-1:0];
        3'd5: ledr <= io_dout[NUM_LEDR-1:0];
        3'd6: attach_en <= io_dout[0];
        default: ;
      endcase
    end
  end

  // a detach request while detaching restarts the full interval
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      det_cnt    <= '0;
      usb_attach <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          usb_attach <= attach_en;
          busy       <= 1'b0;
          if (detach_req) begin
            det_cnt <= DET_LOAD;
            state   <= DETACH;
          end
        end
        default: begin
          usb_attach <= 1'b0;
          busy       <= 1'b1;
          if (detach_req) begin
            det_cnt <= DET_LOAD;
          end else begin
            det_cnt <= det_cnt - 1'b1;
            if (det_cnt == DET_W'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      3'd0: rdata[NUM_KEYS-1:0]  = ~key_deb;
      3'd1: rdata[NUM_KEYS-1:0]  = key_edge;
      3'd2: rdata[NUM_SW-1:0]    = sw_sync;
      3'd3: rdata[4*NUM_HEX-1:0] = hex_val;
      3'd4: rdata[NUM_LEDG-1:0]  = ledg;
      3'd5: rdata[NUM_LEDR-1:0]  = ledr;
      3'd6: rdata[2:0]           = {busy | (state == DETACH), 1'b0, attach_en};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) io_din <= '0;
    else          io_din <= rd_hit ? rdata : '0;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Randomised and directed bench for board_io_ctrl, checked against a cycle-level
// behavioural model built from sample histories and detach-write windows.
module tb_board_io_ctrl;
  localparam int NK = 4, NSW = 10, NG = 8, NR = 10, NH = 4, DB = 16, DET = 100;
  localparam logic [15:0] BASE = 16'h0010;

  logic clk = 1'b0, reset_n = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
  logic [15:0] io_addr = '0, io_dout = '0, io_din;
  logic [NK-1:0] key = '1;
  logic [NSW-1:0] sw = '0;
  logic [7*NH-1:0] hex;
  logic [NG-1:0] ledg;
  logic [NR-1:0] ledr;
  logic usb_attach;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .BASE_ADDR(BASE), .NUM_KEYS(NK), .NUM_SW(NSW), .NUM_LEDG(NG), .NUM_LEDR(NR),
    .NUM_HEX(NH), .DEBOUNCE_CYCLES(DB), .DETACH_CYCLES(DET), .ATTACH_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_dout(io_dout), .io_din(io_din), .key(key), .sw(sw), .hex(hex), .ledg(ledg),
    .ledr(ledr), .usb_attach(usb_attach)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // active-high gfedcba glyphs for 0..F
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [NK-1:0]  khist[$], shist[$];
  logic [NSW-1:0] swhist[$];
  int             dwr[$];
  logic [NK-1:0]  m_deb, m_edge;
  logic [15:0]    m_hex, exp_din;
  logic [7*NH-1:0] m_disp;
  logic [NG-1:0]  m_ledg;
  logic [NR-1:0]  m_ledr;
  logic           m_aen, exp_usb;
  int             ecnt;

  function automatic bit in_win(input int e, input int lo, input int hi);
    foreach (dwr[j]) if (e >= dwr[j] + lo && e <= dwr[j] + hi) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    khist.delete(); shist.delete(); swhist.delete(); dwr.delete();
    m_deb = '1; m_edge = '0; m_hex = '0; m_disp = '1; m_ledg = '0; m_ledr = '0;
    m_aen = 1'b1; exp_din = '0; exp_usb = 1'b0; ecnt = 0;
  endtask

  task automatic model_edge();
    bit hit;
    logic [2:0] off;
    logic [NK-1:0] ks, s, tog, press, clr;
    logic [NSW-1:0] ss;
    bit all_diff;
    hit = (io_addr[15:3] == BASE[15:3]);
    off = io_addr[2:0];
    khist.push_back(key);
    swhist.push_back(sw);
    if (khist.size() > 4) void'(khist.pop_front());
    if (swhist.size() > 4) void'(swhist.pop_front());
    ks = (khist.size() >= 3) ? khist[khist.size()-3] : '1;
    ss = (swhist.size() >= 3) ? swhist[swhist.size()-3] : '0;
    exp_din = '0;
    if (io_rd && hit) begin
      case (off)
        3'd0: exp_din[NK-1:0] = ~m_deb;
        3'd1: exp_din[NK-1:0] = m_edge;
        3'd2: exp_din[NSW-1:0] = ss;
        3'd3: exp_din = m_hex;
        3'd4: exp_din[NG-1:0] = m_ledg;
        3'd5: exp_din[NR-1:0] = m_ledr;
        3'd6: exp_din[2:0] = {in_win(ecnt - 1, 0, DET), 1'b0, m_aen};
        default: ;
      endcase
    end
    shist.push_back(ks);
    if (shist.size() > DB + 4) void'(shist.pop_front());
    tog = '0; press = '0;
    if (shist.size() >= DB) begin
      for (int i = 0; i < NK; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
          s = shist[shist.size()-1-k];
          if (s[i] == m_deb[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          tog[i] = 1'b1;
          press[i] = m_deb[i];
        end
      end
    end
    clr = (io_wr && hit && off == 3'd1) ? io_dout[NK-1:0] : '0;
    m_edge = (m_edge & ~clr) | press;
    m_deb = m_deb ^ tog;
    exp_usb = in_win(ecnt, 1, DET) ? 1'b0 : m_aen;
    if (io_wr && hit) begin
      case (off)
        3'd3: begin
          m_hex = io_dout;
          for (int d = 0; d < NH; d++) m_disp[7*d +: 7] = ~glyph[io_dout[4*d +: 4]];
        end
        3'd4: m_ledg = io_dout[NG-1:0];
        3'd5: m_ledr = io_dout[NR-1:0];
        3'd6: begin
          m_aen = io_dout[0];
          if (io_dout[1]) dwr.push_back(ecnt);
        end
        default: ;
      endcase
    end
    ecnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("io_din", io_din, exp_din);
    check("usb_attach", usb_attach, exp_usb);
    check("ledg", ledg, m_ledg);
    check("ledr", ledr, m_ledr);
    check("hex", hex, m_disp);
  endtask

  task automatic bus(input bit rd, input bit wr, input logic [2:0] off, input logic [15:0] d);
    io_rd = rd; io_wr = wr; io_addr = BASE | {13'd0, off}; io_dout = d;
    step();
    io_rd = 1'b0; io_wr = 1'b0;
  endtask

  function automatic bit press_next();
    logic [NK-1:0] s;
    if (khist.size() < 2 || shist.size() < DB - 1 || m_deb[0] == 1'b0) return 1'b0;
    s = khist[khist.size()-2];
    if (s[0] == m_deb[0]) return 1'b0;
    for (int k = 0; k < DB - 1; k++) begin
      s = shist[shist.size()-1-k];
      if (s[0] == m_deb[0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int low;
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_usb", usb_attach, 0);
    check("rst_hex", hex, 28'hFFFFFFF);
    check("rst_din", io_din, 0);
    check("rst_ledg", ledg, 0);
    check("rst_ledr", ledr, 0);
    reset_n = 1'b1;
    #1 check("usb_at_release", usb_attach, 0);
    step();
    check("usb_one_after_release", usb_attach, 1);

    // key[0] held 40 cycles, then a 10-cycle glitch on key[1]
    for (int c = 0; c < 80; c++) begin
      key[0] = (c < 40) ? 1'b0 : 1'b1;
      key[1] = (c >= 50 && c < 60) ? 1'b0 : 1'b1;
      bus(1'b1, 1'b0, (c % 2 == 0) ? 3'd0 : 3'd1, 16'h0);
    end
    bus(1'b1, 1'b0, 3'd1, 16'h0);
    check("key_edge_captured", io_din, 16'h0001);
    bus(1'b1, 1'b0, 3'd0, 16'h0);
    check("key_released", io_din, 16'h0000);

    // W1C in the same cycle as a new press: the set wins
    key[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (press_next()) found = 1'b1;
      else bus(1'b1, 1'b0, 3'd0, 16'h0);
    end
    check("press_wait", found, 1);
    bus(1'b0, 1'b1, 3'd1, 16'h0001);
    bus(1'b1, 1'b0, 3'd1, 16'h0);
    check("edge_set_wins", io_din, 16'h0001);
    key[0] = 1'b1;
    repeat (30) bus(1'b1, 1'b0, 3'd0, 16'h0);
    bus(1'b0, 1'b1, 3'd1, 16'h000F);
    bus(1'b1, 1'b0, 3'd1, 16'h0);
    check("edge_cleared", io_din, 16'h0000);

    bus(1'b0, 1'b1, 3'd3, 16'h1A2F);
    check("hex_glyphs", hex, {7'h79, 7'h08, 7'h24, 7'h0E});
    bus(1'b1, 1'b0, 3'd3, 16'h0);
    check("hex_readback", io_din, 16'h1A2F);

    for (int c = 0; c < 300; c++) begin
      io_rd = 1'($urandom_range(0, 1));
      io_wr = 1'($urandom_range(0, 1));
      io_addr = ($urandom_range(0, 7) == 0) ? (16'h0100 | 16'($urandom_range(0, 7)))
                                            : (BASE | 16'($urandom_range(0, 7)));
      io_dout = 16'($urandom);
      if ($urandom_range(0, 19) == 0) key[$urandom_range(0, NK-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) sw = NSW'($urandom);
      step();
    end
    io_rd = 1'b0; io_wr = 1'b0;

    // detach for 100 cycles, extended by a re-write 50 cycles in
    bus(1'b0, 1'b1, 3'd6, 16'h0001);
    repeat (120) bus(1'b1, 1'b0, 3'd6, 16'h0);
    check("attached_before_detach", usb_attach, 1);
    bus(1'b0, 1'b1, 3'd6, 16'h0003);
    low = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 50) bus(1'b0, 1'b1, 3'd6, 16'h0003);
      else bus(1'b1, 1'b0, 3'd6, 16'h0);
      if (!usb_attach) low++;
    end
    check("detach_low_cycles", low, 150);
    check("attach_restored", usb_attach, 1);

    bus(1'b0, 1'b1, 3'd6, 16'h0002);
    repeat (30) bus(1'b1, 1'b0, 3'd6, 16'h0);
    bus(1'b0, 1'b1, 3'd6, 16'h0000);
    repeat (110) bus(1'b1, 1'b0, 3'd6, 16'h0);
    check("stay_detached", usb_attach, 0);
    bus(1'b0, 1'b1, 3'd6, 16'h0001);
    bus(1'b1, 1'b0, 3'd6, 16'h0);
    check("reattached", usb_attach, 1);

    // unmapped offset and foreign base
    bus(1'b0, 1'b1, 3'd4, 16'h00A5);
    bus(1'b1, 1'b1, 3'd7, 16'hFFFF);
    check("unmapped_rd", io_din, 16'h0000);
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 16'h0034; io_dout = 16'hFFFF;
    step();
    io_rd = 1'b0; io_wr = 1'b0;
    check("foreign_rd", io_din, 16'h0000);
    check("foreign_wr_ledg", ledg, 8'hA5);

    // reset in the middle of a detach
    bus(1'b0, 1'b1, 3'd6, 16'h0003);
    repeat (20) bus(1'b1, 1'b0, 3'd6, 16'h0);
    reset_n = 1'b0;
    #1;
    check("midrst_usb", usb_attach, 0);
    check("midrst_hex", hex, 28'hFFFFFFF);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    check("midrst_reattach", usb_attach, 1);
    bus(1'b1, 1'b0, 3'd6, 16'h0);
    check("midrst_ctrl", io_din, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
